// File: rtl/d_input_debouncer.sv
// Input conditioner in front of the D flip-flop: synchronises a raw pin and accepts
// a new level only after it has been stable for DEBOUNCE_CYCLES synchronised cycles.
module d_input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    input  logic en,
    output logic q_clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b10,
        CHECK_LOW  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   d_sync_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   q_clean_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   busy_r;
    logic                   q_nxt_s;
    logic                   rise_nxt_s;
    logic                   fall_nxt_s;
    logic                   busy_nxt_s;

    // Metastability chain on the raw pin; free-running regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d_raw};
        end
    end

    assign d_sync_s = sync_r[SYNC_STAGES-1];

    // State and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE_LOW;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state: reversion and enable loss are tested before count completion,
    // so a sample that flips on the final cycle still aborts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE_LOW: begin
                if (en && d_sync_s) begin
                    state_nxt_s = CHECK_HIGH;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE_LOW;
                    cnt_nxt_s   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!en || !d_sync_s) begin
                    state_nxt_s = IDLE_LOW;
                    cnt_nxt_s   = '0;
                end else if (cnt_r >= CNT_MAX) begin
                    state_nxt_s = IDLE_HIGH;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = CHECK_HIGH;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (en && !d_sync_s) begin
                    state_nxt_s = CHECK_LOW;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE_HIGH;
                    cnt_nxt_s   = '0;
                end
            end
            CHECK_LOW: begin
                if (!en || d_sync_s) begin
                    state_nxt_s = IDLE_HIGH;
                    cnt_nxt_s   = '0;
                end else if (cnt_r >= CNT_MAX) begin
                    state_nxt_s = IDLE_LOW;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = CHECK_LOW;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE_LOW;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output decode from the transition about to be taken.
    always_comb begin
        q_nxt_s    = q_clean_r;
        rise_nxt_s = 1'b0;
        fall_nxt_s = 1'b0;
        busy_nxt_s = (state_nxt_s == CHECK_HIGH) || (state_nxt_s == CHECK_LOW);
        if ((state_r == CHECK_HIGH) && (state_nxt_s == IDLE_HIGH)) begin
            q_nxt_s    = 1'b1;
            rise_nxt_s = 1'b1;
        end else if ((state_r == CHECK_LOW) && (state_nxt_s == IDLE_LOW)) begin
            q_nxt_s    = 1'b0;
            fall_nxt_s = 1'b1;
        end else begin
            q_nxt_s    = q_clean_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_clean_r <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            q_clean_r <= q_nxt_s;
            rise_r    <= rise_nxt_s;
            fall_r    <= fall_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign q_clean    = q_clean_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_d_input_debouncer.sv
// Directed bench for d_input_debouncer with default parameters (2 sync stages, 4 debounce cycles).
module tb_d_input_debouncer;

    logic clk;
    logic rst_n;
    logic d_raw;
    logic en;
    logic q_clean;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks;
    int failures;

    d_input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_raw     (d_raw),
        .en        (en),
        .q_clean   (q_clean),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d_raw = 1'b0;
        en    = 1'b1;
        #11;
        checks++;
        if ({q_clean, busy, rise_pulse, fall_pulse} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold q/busy/rise/fall=%b expected 0000", {q_clean, busy, rise_pulse, fall_pulse});
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({q_clean, busy, rise_pulse, fall_pulse} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d q/busy/rise/fall=%b expected 0000", i, {q_clean, busy, rise_pulse, fall_pulse});
            end
        end
    endtask

    // Edge n=0 is the first edge sampling the new level.
    task automatic test_clean_rise();
        logic [7:0] exp_busy;
        logic [7:0] exp_q;
        logic [7:0] exp_rise;
        exp_busy = 8'b0011_1100;
        exp_q    = 8'b1100_0000;
        exp_rise = 8'b0100_0000;
        d_raw = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if ({busy, q_clean, rise_pulse, fall_pulse} !== {exp_busy[n], exp_q[n], exp_rise[n], 1'b0}) begin
                failures++;
                $display("FAIL clean_rise n=%0d busy/q/rise/fall=%b expected %b", n,
                         {busy, q_clean, rise_pulse, fall_pulse}, {exp_busy[n], exp_q[n], exp_rise[n], 1'b0});
            end
        end
    endtask

    task automatic test_fall_pulse();
        logic [7:0] exp_busy;
        logic [7:0] exp_q;
        logic [7:0] exp_fall;
        exp_busy = 8'b0011_1100;
        exp_q    = 8'b0011_1111;
        exp_fall = 8'b0100_0000;
        d_raw = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if ({busy, q_clean, rise_pulse, fall_pulse} !== {exp_busy[n], exp_q[n], 1'b0, exp_fall[n]}) begin
                failures++;
                $display("FAIL fall_pulse n=%0d busy/q/rise/fall=%b expected %b", n,
                         {busy, q_clean, rise_pulse, fall_pulse}, {exp_busy[n], exp_q[n], 1'b0, exp_fall[n]});
            end
        end
    endtask

    // Raw pattern 1,1,0,1,1,1,0 reaches the FSM two edges late and never completes a count.
    task automatic test_bounce();
        logic [6:0]  pat;
        logic [13:0] exp_busy;
        pat      = 7'b011_1011;
        exp_busy = 14'b00_0000_1110_1100;
        for (int n = 0; n < 14; n++) begin
            d_raw = (n < 7) ? pat[n] : 1'b0;
            tick();
            checks++;
            if ({busy, q_clean, rise_pulse, fall_pulse} !== {exp_busy[n], 3'b000}) begin
                failures++;
                $display("FAIL bounce n=%0d busy/q/rise/fall=%b expected %b", n,
                         {busy, q_clean, rise_pulse, fall_pulse}, {exp_busy[n], 3'b000});
            end
        end
    endtask

    // Level held for exactly DEBOUNCE_CYCLES synchronised cycles, then drops on the completing cycle.
    task automatic test_reversion();
        d_raw = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (n == 3) begin
                d_raw = 1'b0;
            end else begin
                d_raw = d_raw;
            end
            if (n == 5) begin
                checks++;
                if ({busy, q_clean} !== 2'b10) begin
                    failures++;
                    $display("FAIL reversion_count4 busy/q=%b expected 10", {busy, q_clean});
                end
            end else if (n >= 6) begin
                checks++;
                if ({busy, q_clean, rise_pulse, fall_pulse} !== 4'b0000) begin
                    failures++;
                    $display("FAIL reversion_abort n=%0d busy/q/rise/fall=%b expected 0000", n,
                             {busy, q_clean, rise_pulse, fall_pulse});
                end
            end else begin
                checks = checks;
            end
        end
    endtask

    task automatic test_enable_abort();
        logic [10:0] exp_busy;
        exp_busy = 11'b011_1101_1100;
        d_raw = 1'b1;
        for (int n = 0; n < 11; n++) begin
            tick();
            checks++;
            if ({busy, q_clean, rise_pulse} !== {exp_busy[n], (n == 10), (n == 10)}) begin
                failures++;
                $display("FAIL enable_abort n=%0d busy/q/rise=%b expected %b", n,
                         {busy, q_clean, rise_pulse}, {exp_busy[n], (n == 10), (n == 10)});
            end
            if (n == 4) begin
                en = 1'b0;
            end else begin
                en = 1'b1;
            end
        end
    endtask

    // Reach q_clean=1, start a fall check, then pull reset between edges.
    task automatic test_async_reset();
        d_raw = 1'b1;
        for (int n = 0; n < 8; n++) tick();
        checks++;
        if (q_clean !== 1'b1) begin
            failures++;
            $display("FAIL async_setup q=%b expected 1", q_clean);
        end
        d_raw = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if ({busy, q_clean} !== 2'b11) begin
            failures++;
            $display("FAIL async_midcheck busy/q=%b expected 11", {busy, q_clean});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({q_clean, busy, rise_pulse, fall_pulse} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset q/busy/rise/fall=%b expected 0000", {q_clean, busy, rise_pulse, fall_pulse});
        end
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if ({q_clean, busy, rise_pulse, fall_pulse} !== 4'b0000) begin
                failures++;
                $display("FAIL async_after n=%0d q/busy/rise/fall=%b expected 0000", n,
                         {q_clean, busy, rise_pulse, fall_pulse});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clean_rise();
        test_fall_pulse();
        test_bounce();
        test_reversion();
        test_enable_abort();
        d_raw = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
